hv_cmd_dispatcher: RTL and testbench

//  Single-outstanding scheduler on the output side of hv_commandQ. Waits for cq_cout_ready,

---
 rtl/hv_cmd_pkg.sv | 40 ++++
 rtl/hv_cmd_dispatcher_if.sv | 32 +++
 rtl/hv_cdb_checksum.sv | 25 ++
 rtl/hv_cmd_dispatcher.sv | 143 ++++++++++++++
 tb/tb_hv_cmd_dispatcher.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_cmd_pkg.sv
// Shared definitions for the command-queue dispatcher and the host-side CDB builder:
// opcodes, completion status codes, CDB field offsets and the dispatcher state type.
package hv_cmd_pkg;

  localparam int unsigned CDB_WIDTH   = 256;
  localparam int unsigned CDB_OP_LSB  = 0;
  localparam int unsigned CDB_TAG_LSB = 8;
  localparam int unsigned CDB_CHK_LSB = 128;

  localparam logic [7:0] BSM_WRITE = 8'h40;
  localparam logic [7:0] BSM_READ  = 8'h30;
  // Recognised by the queue but never handed to the BSM engine.
  localparam logic [7:0] QUERY     = 8'h20;

  localparam logic [7:0] CMD_ST_IDLE       = 8'h00;
  localparam logic [7:0] CMD_ST_READ_DONE  = 8'h06;
  localparam logic [7:0] CMD_ST_WRITE_DONE = 8'h07;
  localparam logic [7:0] CMD_ST_ERROR      = 8'h0F;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitOe,
    StCapt,
    StCheck,
    StDispatch,
    StWaitDone,
    StReport
  } disp_state_e;

  function automatic logic is_dispatchable(input logic [7:0] op);
    return (op == BSM_WRITE) || (op == BSM_READ);
  endfunction

  // Only meaningful for dispatchable opcodes.
  function automatic logic [7:0] done_code(input logic [7:0] op);
    return (op == BSM_WRITE) ? CMD_ST_WRITE_DONE : CMD_ST_READ_DONE;
  endfunction

endpackage

// File: rtl/hv_cmd_dispatcher_if.sv
// Queue-side and engine-side signals of the command dispatcher.
// master: the dispatcher; slave: the command queue plus BSM engine.
interface hv_cmd_dispatcher_if #(
  parameter int unsigned CMD_IO_WIDTH = 64
);
  logic                      cq_cout_ready;
  logic                      cmd_request;
  logic                      cmd_oe;
  logic [CMD_IO_WIDTH-1:0]   cmd_out;
  logic [7:0]                op_index;
  logic [7:0]                cmd_op_status;
  logic                      eng_valid;
  logic                      eng_ready;
  logic [4*CMD_IO_WIDTH-1:0] eng_cdb;
  logic [7:0]                eng_op;
  logic [7:0]                eng_tag;
  logic                      eng_done;
  logic                      busy;
  logic                      err_pulse;

  modport master (
    input  cq_cout_ready, cmd_oe, cmd_out, eng_ready, eng_done,
    output cmd_request, op_index, cmd_op_status, eng_valid, eng_cdb, eng_op, eng_tag,
           busy, err_pulse
  );

  modport slave (
    output cq_cout_ready, cmd_oe, cmd_out, eng_ready, eng_done,
    input  cmd_request, op_index, cmd_op_status, eng_valid, eng_cdb, eng_op, eng_tag,
           busy, err_pulse
  );
endinterface

// File: rtl/hv_cdb_checksum.sv
// Combinational CDB checksum: chk byte k is the XOR of CDB bytes k, 4+k, ..., 28+k,
// skipping 16+k, which is where the checksum itself lives. Shared with the CDB builder.
module hv_cdb_checksum
  import hv_cmd_pkg::*;
(
  input  logic [CDB_WIDTH-1:0] cdb,
  output logic [31:0]          chk,
  output logic                 match
);

  // Fold the seven covered words byte-lane by byte-lane.
  always_comb begin
    chk = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (j != 4) begin
          chk[8*k +: 8] = chk[8*k +: 8] ^ cdb[8*(4*j+k) +: 8];
        end
      end
    end
  end

  assign match = (chk == cdb[CDB_CHK_LSB +: 32]);

endmodule

// File: rtl/hv_cmd_dispatcher.sv
// Single-outstanding scheduler between hv_commandQ and the BSM engine: requests one
// command, captures its 4-beat CDB, validates it, dispatches it and writes back status.
module hv_cmd_dispatcher
  import hv_cmd_pkg::*;
#(
  parameter int unsigned CMD_IO_WIDTH  = 64,
  parameter int unsigned OE_TIMEOUT    = 64,
  parameter logic [7:0]  ST_IDLE_CODE  = CMD_ST_IDLE,
  parameter logic [7:0]  ST_ERROR_CODE = CMD_ST_ERROR
) (
  input logic                 clk,
  input logic                 reset,
  hv_cmd_dispatcher_if.master bus
);

  localparam int unsigned CdbW = 4 * CMD_IO_WIDTH;
  localparam int unsigned CntW = (OE_TIMEOUT > 1) ? $clog2(OE_TIMEOUT) : 1;
  localparam logic [CntW-1:0] OeLast = CntW'(OE_TIMEOUT - 1);

  disp_state_e     state_q;
  logic [1:0]      beat_cnt_q;
  logic [CntW-1:0] oe_cnt_q;
  logic [CdbW-1:0] cdb_q;
  logic            cmd_request_q;
  logic            eng_valid_q;
  logic [7:0]      op_index_q;
  logic [7:0]      status_q;
  logic            busy_q;
  logic            err_q;

  logic [31:0] cs_chk;
  logic        cs_match;
  logic [7:0]  opcode;
  logic [7:0]  tag;

  assign opcode = cdb_q[CDB_OP_LSB +: 8];
  assign tag    = cdb_q[CDB_TAG_LSB +: 8];

  hv_cdb_checksum u_checksum (
    .cdb   (cdb_q),
    .chk   (cs_chk),
    .match (cs_match)
  );

  // Only the match flag matters here; the raw checksum serves the host-side builder.
  logic unused_chk;
  assign unused_chk = ^cs_chk;

  // Dispatcher FSM with its beat/timeout counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      beat_cnt_q    <= '0;
      oe_cnt_q      <= '0;
      cdb_q         <= '0;
      cmd_request_q <= 1'b0;
      eng_valid_q   <= 1'b0;
      op_index_q    <= '0;
      status_q      <= ST_IDLE_CODE;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Pulses and the status code fall back every cycle unless a state sets them.
      cmd_request_q <= 1'b0;
      err_q         <= 1'b0;
      status_q      <= ST_IDLE_CODE;
      unique case (state_q)
        StIdle: begin
          if (bus.cq_cout_ready) begin
            state_q       <= StReq;
            cmd_request_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        StReq: begin
          state_q  <= StWaitOe;
          oe_cnt_q <= '0;
        end
        StWaitOe: begin
          if (bus.cmd_oe) begin
            cdb_q[CMD_IO_WIDTH-1:0] <= bus.cmd_out;
            beat_cnt_q              <= 2'd1;
            state_q                 <= StCapt;
          end else if (oe_cnt_q == OeLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            oe_cnt_q <= oe_cnt_q + 1'b1;
          end
        end
        StCapt: begin
          // Later beats follow back-to-back; cmd_oe only qualifies beat 0.
          cdb_q[CMD_IO_WIDTH*int'(beat_cnt_q) +: CMD_IO_WIDTH] <= bus.cmd_out;
          beat_cnt_q <= beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (!cs_match || !is_dispatchable(opcode)) begin
            state_q    <= StReport;
            op_index_q <= tag;
            status_q   <= ST_ERROR_CODE;
            err_q      <= 1'b1;
          end else begin
            state_q     <= StDispatch;
            eng_valid_q <= 1'b1;
          end
        end
        StDispatch: begin
          if (bus.eng_ready) begin
            eng_valid_q <= 1'b0;
            state_q     <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (bus.eng_done) begin
            state_q    <= StReport;
            op_index_q <= tag;
            status_q   <= done_code(opcode);
          end
        end
        StReport: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_request   = cmd_request_q;
  assign bus.op_index      = op_index_q;
  assign bus.cmd_op_status = status_q;
  assign bus.eng_valid     = eng_valid_q;
  assign bus.eng_cdb       = cdb_q;
  assign bus.eng_op        = opcode;
  assign bus.eng_tag       = tag;
  assign bus.busy          = busy_q;
  assign bus.err_pulse     = err_q;

endmodule

// File: tb/tb_hv_cmd_dispatcher.sv
// Directed bench for hv_cmd_dispatcher: the initial block plays command queue and engine,
// a negedge monitor pops expected dispatches and status write-backs from scoreboards.
module tb_hv_cmd_dispatcher;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] st;
  } rep_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mism = 0;
  int   err_seen = 0;

  logic [255:0] exp_cdb_q[$];
  rep_t         exp_rep_q[$];

  hv_cmd_dispatcher_if #(.CMD_IO_WIDTH(64)) q ();

  hv_cmd_dispatcher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random CDB with the given opcode/tag and a correct checksum in bytes 16..19.
  function automatic logic [255:0] make_cdb(input logic [7:0] op, input logic [7:0] tg);
    logic [7:0]   b[32];
    logic [255:0] r;
    int           offs[7] = '{0, 4, 8, 12, 20, 24, 28};
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom_range(0, 255));
    b[0] = op;
    b[1] = tg;
    for (int k = 0; k < 4; k++) begin
      b[16+k] = 8'h00;
      for (int j = 0; j < 7; j++) b[16+k] = b[16+k] ^ b[offs[j]+k];
    end
    for (int i = 0; i < 32; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_request"}, q.cmd_request, 0);
    check({pfx, "_op_index"}, q.op_index, 0);
    check({pfx, "_status"}, q.cmd_op_status, 8'h00);
    check({pfx, "_eng_valid"}, q.eng_valid, 0);
    check({pfx, "_eng_cdb"}, q.eng_cdb, 0);
    check({pfx, "_eng_op"}, q.eng_op, 0);
    check({pfx, "_eng_tag"}, q.eng_tag, 0);
    check({pfx, "_busy"}, q.busy, 0);
    check({pfx, "_err"}, q.err_pulse, 0);
  endtask

  // Raise cq_cout_ready until the request pulse is seen; leaves cq_cout_ready low.
  task automatic wait_request();
    int n = 0;
    q.cq_cout_ready = 1'b1;
    while (q.cmd_request !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_seen", q.cmd_request, 1);
    q.cq_cout_ready = 1'b0;
  endtask

  // Request a command and deliver its four beats; returns in the CHECK cycle.
  task automatic issue(input logic [255:0] cdb);
    wait_request();
    step();
    check("req_one_cycle", q.cmd_request, 0);
    q.cmd_oe  = 1'b1;
    q.cmd_out = cdb[63:0];
    for (int b = 1; b < 4; b++) begin
      step();
      q.cmd_oe  = 1'b0;
      q.cmd_out = cdb[64*b +: 64];
    end
    step();
    q.cmd_out = '0;
  endtask

  // Engine side: accept after `delay` cycles, finish 5 cycles after accept.
  task automatic engine(input int delay, input logic [255:0] cdb, input logic [7:0] st);
    int n = 0;
    q.eng_ready = 1'b0;
    step();
    while (q.eng_valid !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check("dispatch_latency", n, 0);
    for (int i = 0; i < delay; i++) begin
      check("hold_valid", q.eng_valid, 1);
      check("hold_cdb", q.eng_cdb, cdb);
      q.eng_done = (i == 3);  // stray done while still dispatching
      step();
    end
    q.eng_done = 1'b0;
    check("valid_at_accept", q.eng_valid, 1);
    q.eng_ready = 1'b1;
    step();
    q.eng_ready = 1'b0;
    check("valid_dropped", q.eng_valid, 0);
    repeat (4) step();
    check("no_early_report", q.cmd_op_status, 8'h00);
    q.eng_done = 1'b1;
    step();
    q.eng_done = 1'b0;
    check("report_status", q.cmd_op_status, st);
    check("report_index", q.op_index, cdb[15:8]);
    step();
    check("status_back_idle", q.cmd_op_status, 8'h00);
    check("busy_cleared", q.busy, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (q.eng_valid === 1'b1 && q.eng_ready === 1'b1) begin
        if (exp_cdb_q.size() == 0) begin
          check("unexpected_dispatch", 1, 0);
        end else begin
          logic [255:0] e;
          e = exp_cdb_q.pop_front();
          check("sb_cdb", q.eng_cdb, e);
          check("sb_op", q.eng_op, e[7:0]);
          check("sb_tag", q.eng_tag, e[15:8]);
        end
      end
      if (q.cmd_op_status !== 8'h00) begin
        if (exp_rep_q.size() == 0) begin
          check("unexpected_status", q.cmd_op_status, 8'h00);
        end else begin
          rep_t r;
          r = exp_rep_q.pop_front();
          check("sb_index", q.op_index, r.tag);
          check("sb_status", q.cmd_op_status, r.st);
        end
      end
      if (q.err_pulse === 1'b1) err_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] cdb;
    int           n;

    reset           = 1'b1;
    q.cq_cout_ready = 1'b0;
    q.cmd_oe        = 1'b0;
    q.cmd_out       = '0;
    q.eng_ready     = 1'b0;
    q.eng_done      = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // 1) three BSM_WRITE commands, tags 0..2
    for (int t = 0; t < 3; t++) begin
      cdb = make_cdb(8'h40, 8'(t));
      exp_cdb_q.push_back(cdb);
      exp_rep_q.push_back('{tag: 8'(t), st: 8'h07});
      issue(cdb);
      engine(0, cdb, 8'h07);
    end

    // 2) BSM_READ tag 5, engine stalls 10 cycles
    cdb = make_cdb(8'h30, 8'h05);
    exp_cdb_q.push_back(cdb);
    exp_rep_q.push_back('{tag: 8'h05, st: 8'h06});
    issue(cdb);
    engine(10, cdb, 8'h06);

    // 3) corrupted checksum byte 16
    q.eng_ready = 1'b1;
    cdb = make_cdb(8'h40, 8'h0A);
    cdb[135:128] = cdb[135:128] ^ 8'h01;
    exp_rep_q.push_back('{tag: 8'h0A, st: 8'h0F});
    issue(cdb);
    step();
    check("cs_err_status", q.cmd_op_status, 8'h0F);
    check("cs_err_index", q.op_index, 8'h0A);
    check("cs_err_pulse", q.err_pulse, 1);
    check("cs_err_no_valid", q.eng_valid, 0);
    step();
    check("cs_err_status_idle", q.cmd_op_status, 8'h00);
    check("cs_err_pulse_once", q.err_pulse, 0);

    // 4) unknown opcode with a good checksum
    cdb = make_cdb(8'h70, 8'h0B);
    exp_rep_q.push_back('{tag: 8'h0B, st: 8'h0F});
    issue(cdb);
    step();
    check("op_err_status", q.cmd_op_status, 8'h0F);
    check("op_err_index", q.op_index, 8'h0B);
    check("op_err_no_valid", q.eng_valid, 0);
    step();
    check("op_err_busy", q.busy, 0);
    q.eng_ready = 1'b0;

    // 5) cmd_oe withheld: 64 WAIT_OE cycles, err_pulse visible the cycle after
    wait_request();
    n = 0;
    do begin
      step();
      n++;
      if (q.cmd_request !== 1'b0) check("timeout_no_request", q.cmd_request, 0);
    end while (q.err_pulse !== 1'b1 && n < 100);
    check("timeout_cycle", n, 65);
    check("timeout_busy", q.busy, 0);
    check("timeout_status", q.cmd_op_status, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check("timeout_no_reissue", q.cmd_request, 0);
    end
    cdb = make_cdb(8'h30, 8'h11);
    exp_cdb_q.push_back(cdb);
    exp_rep_q.push_back('{tag: 8'h11, st: 8'h06});
    issue(cdb);
    engine(0, cdb, 8'h06);

    // 6) reset while beat 2 is being captured
    cdb = make_cdb(8'h40, 8'h21);
    wait_request();
    step();
    q.cmd_oe  = 1'b1;
    q.cmd_out = cdb[63:0];
    step();
    q.cmd_oe  = 1'b0;
    q.cmd_out = cdb[127:64];
    step();
    q.cmd_out = cdb[191:128];
    reset     = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset     = 1'b0;
    q.cmd_out = '0;
    step();
    cdb = make_cdb(8'h40, 8'h22);
    exp_cdb_q.push_back(cdb);
    exp_rep_q.push_back('{tag: 8'h22, st: 8'h07});
    issue(cdb);
    engine(2, cdb, 8'h07);

    repeat (3) step();
    check("sb_dispatch_drained", exp_cdb_q.size(), 0);
    check("sb_report_drained", exp_rep_q.size(), 0);
    check("err_pulse_count", err_seen, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
